// File: rtl/alu_issue_stage.sv
// ID/EX issue register for the execute-stage ALU: decodes ALU ops, forwards
// operands and holds one entry under a valid/ready handshake with stall/flush.
module alu_issue_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic              fwd1_we,
  input  logic [4:0]        fwd1_rd,
  input  logic [DATA_W-1:0] fwd1_data,
  input  logic              fwd2_we,
  input  logic [4:0]        fwd2_rd,
  input  logic [DATA_W-1:0] fwd2_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  output logic [2:0]        ex_op,
  output logic [4:0]        ex_rd,
  output logic              ex_we,
  output logic              ex_illegal,
  output logic [CNT_W-1:0]  illegal_cnt
);

  localparam int unsigned IMM_W = 16;
  localparam int unsigned EXT_W = DATA_W - IMM_W;

  localparam logic [2:0] OP_NOR  = 3'b000;
  localparam logic [2:0] OP_AND  = 3'b001;
  localparam logic [2:0] OP_OR   = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_NONE = 3'b111;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_ANDI  = 6'h0C;
  localparam logic [5:0] OPC_ORI   = 6'h0D;
  localparam logic [5:0] OPC_NORI  = 6'h0E;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;

  // Instruction fields
  logic [5:0]       w_opc;
  logic [4:0]       w_rs;
  logic [4:0]       w_rt;
  logic [4:0]       w_rd;
  logic [5:0]       w_funct;
  logic [IMM_W-1:0] w_imm;
  logic             w_unused_shamt;

  assign w_opc          = instr[31:26];
  assign w_rs           = instr[25:21];
  assign w_rt           = instr[20:16];
  assign w_rd           = instr[15:11];
  assign w_funct        = instr[5:0];
  assign w_imm          = instr[15:0];
  assign w_unused_shamt = ^instr[10:6];

  // Registered state
  logic              r_valid;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [2:0]        r_op;
  logic [4:0]        r_rd;
  logic              r_we;
  logic              r_illegal;
  logic [CNT_W-1:0]  r_cnt;

  // Decode results
  logic              w_legal;
  logic [2:0]        w_op;
  logic              w_use_imm;
  logic              w_sext;
  logic [4:0]        w_dest;
  logic [DATA_W-1:0] w_imm_ext;
  logic [DATA_W-1:0] w_fwd_a;
  logic [DATA_W-1:0] w_fwd_b;
  logic [DATA_W-1:0] w_a;
  logic [DATA_W-1:0] w_b;
  logic              w_we;
  logic              w_accept;
  logic              w_cnt_inc;

  // Operand bypass: r0 reads as zero, EX/MEM beats MEM/WB beats regfile.
  function automatic logic [DATA_W-1:0] fwd_sel(
    input logic [4:0]        r,
    input logic [DATA_W-1:0] rf,
    input logic              we1,
    input logic [4:0]        rd1,
    input logic [DATA_W-1:0] d1,
    input logic              we2,
    input logic [4:0]        rd2,
    input logic [DATA_W-1:0] d2
  );
    logic [DATA_W-1:0] v;
    if (r == 5'd0)                 v = '0;
    else if (we1 && (rd1 == r))    v = d1;
    else if (we2 && (rd2 == r))    v = d2;
    else                           v = rf;
    return v;
  endfunction

  always_comb begin
    w_legal   = 1'b0;
    w_op      = OP_NONE;
    w_use_imm = 1'b0;
    w_sext    = 1'b0;
    w_dest    = 5'd0;
    unique case (w_opc)
      OPC_RTYPE: begin
        w_dest = w_rd;
        unique case (w_funct)
          FN_ADD:  begin w_legal = 1'b1; w_op = OP_ADD; end
          FN_SUB:  begin w_legal = 1'b1; w_op = OP_SUB; end
          FN_AND:  begin w_legal = 1'b1; w_op = OP_AND; end
          FN_OR:   begin w_legal = 1'b1; w_op = OP_OR;  end
          FN_NOR:  begin w_legal = 1'b1; w_op = OP_NOR; end
          default: begin w_legal = 1'b0; w_op = OP_NONE; end
        endcase
      end
      OPC_ADDI: begin
        w_legal = 1'b1; w_op = OP_ADD; w_use_imm = 1'b1; w_sext = 1'b1; w_dest = w_rt;
      end
      OPC_ANDI: begin
        w_legal = 1'b1; w_op = OP_AND; w_use_imm = 1'b1; w_dest = w_rt;
      end
      OPC_ORI: begin
        w_legal = 1'b1; w_op = OP_OR;  w_use_imm = 1'b1; w_dest = w_rt;
      end
      OPC_NORI: begin
        w_legal = 1'b1; w_op = OP_NOR; w_use_imm = 1'b1; w_dest = w_rt;
      end
      default: begin
        w_legal = 1'b0;
        w_op    = OP_NONE;
      end
    endcase
    if (!w_legal) w_dest = 5'd0;
  end

  assign w_imm_ext = w_sext ? {{EXT_W{w_imm[IMM_W-1]}}, w_imm}
                            : {{EXT_W{1'b0}}, w_imm};

  assign w_fwd_a = fwd_sel(w_rs, rs_data, fwd1_we, fwd1_rd, fwd1_data,
                           fwd2_we, fwd2_rd, fwd2_data);
  assign w_fwd_b = fwd_sel(w_rt, rt_data, fwd1_we, fwd1_rd, fwd1_data,
                           fwd2_we, fwd2_rd, fwd2_data);

  assign w_a  = w_legal ? w_fwd_a : '0;
  assign w_b  = !w_legal ? '0 : (w_use_imm ? w_imm_ext : w_fwd_b);
  assign w_we = w_legal && (w_dest != 5'd0);

  // Handshake: flush blocks acceptance outright
  assign in_ready  = !flush && (!r_valid || out_ready);
  assign w_accept  = in_valid && in_ready;
  assign w_cnt_inc = w_accept && !w_legal && (r_cnt != {CNT_W{1'b1}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  // Payload only moves on accept, so it is stable during stall and flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a       <= '0;
      r_b       <= '0;
      r_op      <= OP_NONE;
      r_rd      <= 5'd0;
      r_we      <= 1'b0;
      r_illegal <= 1'b0;
    end else if (w_accept) begin
      r_a       <= w_a;
      r_b       <= w_b;
      r_op      <= w_op;
      r_rd      <= w_dest;
      r_we      <= w_we;
      r_illegal <= !w_legal;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_cnt_inc) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign out_valid   = r_valid;
  assign ex_a        = r_a;
  assign ex_b        = r_b;
  assign ex_op       = r_op;
  assign ex_rd       = r_rd;
  assign ex_we       = r_we;
  assign ex_illegal  = r_illegal;
  assign illegal_cnt = r_cnt;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage; a second narrow-counter instance checks saturation.
module tb_alu_issue_stage;

  localparam int unsigned DATA_W = 32;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       instr;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic              fwd1_we;
  logic [4:0]        fwd1_rd;
  logic [DATA_W-1:0] fwd1_data;
  logic              fwd2_we;
  logic [4:0]        fwd2_rd;
  logic [DATA_W-1:0] fwd2_data;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] ex_a;
  logic [DATA_W-1:0] ex_b;
  logic [2:0]        ex_op;
  logic [4:0]        ex_rd;
  logic              ex_we;
  logic              ex_illegal;
  logic [15:0]       illegal_cnt;

  logic              unused_s_in_ready;
  logic              unused_s_out_valid;
  logic [DATA_W-1:0] unused_s_a;
  logic [DATA_W-1:0] unused_s_b;
  logic [2:0]        unused_s_op;
  logic [4:0]        unused_s_rd;
  logic              unused_s_we;
  logic              unused_s_illegal;
  logic [1:0]        s_cnt;

  int n_chk;
  int n_pass;

  alu_issue_stage #(.DATA_W(DATA_W), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .rs_data(rs_data), .rt_data(rt_data),
    .fwd1_we(fwd1_we), .fwd1_rd(fwd1_rd), .fwd1_data(fwd1_data),
    .fwd2_we(fwd2_we), .fwd2_rd(fwd2_rd), .fwd2_data(fwd2_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .ex_a(ex_a), .ex_b(ex_b), .ex_op(ex_op), .ex_rd(ex_rd), .ex_we(ex_we),
    .ex_illegal(ex_illegal), .illegal_cnt(illegal_cnt)
  );

  alu_issue_stage #(.DATA_W(DATA_W), .CNT_W(2)) u_dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(unused_s_in_ready),
    .instr(instr), .rs_data(rs_data), .rt_data(rt_data),
    .fwd1_we(fwd1_we), .fwd1_rd(fwd1_rd), .fwd1_data(fwd1_data),
    .fwd2_we(fwd2_we), .fwd2_rd(fwd2_rd), .fwd2_data(fwd2_data),
    .flush(flush), .out_valid(unused_s_out_valid), .out_ready(out_ready),
    .ex_a(unused_s_a), .ex_b(unused_s_b), .ex_op(unused_s_op), .ex_rd(unused_s_rd),
    .ex_we(unused_s_we), .ex_illegal(unused_s_illegal), .illegal_cnt(s_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [31:0] mk_r(input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] mk_i(input logic [5:0] opc, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] imm);
    return {opc, rs, rt, imm};
  endfunction

  task automatic drive(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1;
    instr    = ins;
    rs_data  = a;
    rt_data  = b;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ex(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] op, input logic [4:0] rd, input logic we);
    chk({tag, ".valid"}, 64'(out_valid), 64'(1));
    chk({tag, ".a"},     64'(ex_a),      64'(a));
    chk({tag, ".b"},     64'(ex_b),      64'(b));
    chk({tag, ".op"},    64'(ex_op),     64'(op));
    chk({tag, ".rd"},    64'(ex_rd),     64'(rd));
    chk({tag, ".we"},    64'(ex_we),     64'(we));
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    rst_n = 1'b0; in_valid = 1'b0; instr = '0; rs_data = '0; rt_data = '0;
    fwd1_we = 1'b0; fwd1_rd = '0; fwd1_data = '0;
    fwd2_we = 1'b0; fwd2_rd = '0; fwd2_data = '0;
    flush = 1'b0; out_ready = 1'b1;

    step(); step();
    chk("rst.valid", 64'(out_valid),   64'(0));
    chk("rst.op",    64'(ex_op),       64'(3'b111));
    chk("rst.a",     64'(ex_a),        64'(0));
    chk("rst.cnt",   64'(illegal_cnt), 64'(0));
    rst_n = 1'b1;
    #1;
    chk("rst.in_ready", 64'(in_ready), 64'(1));

    drive(mk_r(5'd1, 5'd2, 5'd3, 6'h20), 32'd5, 32'd7);
    step(); chk_ex("add", 32'd5, 32'd7, 3'b100, 5'd3, 1'b1);
    chk("add.illegal", 64'(ex_illegal), 64'(0));

    drive(mk_i(6'h08, 5'd1, 5'd4, 16'hFFFF), 32'd5, 32'd0);
    step(); chk_ex("addi", 32'd5, 32'hFFFF_FFFF, 3'b100, 5'd4, 1'b1);

    drive(mk_i(6'h0D, 5'd1, 5'd5, 16'h8000), 32'd5, 32'd0);
    step(); chk_ex("ori", 32'd5, 32'h0000_8000, 3'b010, 5'd5, 1'b1);

    drive(mk_i(6'h0C, 5'd1, 5'd6, 16'hFFFF), 32'd3, 32'd0);
    step(); chk_ex("andi", 32'd3, 32'h0000_FFFF, 3'b001, 5'd6, 1'b1);

    drive(mk_i(6'h0E, 5'd2, 5'd6, 16'h00F0), 32'd1, 32'd0);
    step(); chk_ex("nori", 32'd1, 32'h0000_00F0, 3'b000, 5'd6, 1'b1);

    drive(mk_r(5'd1, 5'd2, 5'd0, 6'h22), 32'd9, 32'd4);
    step(); chk_ex("sub_rd0", 32'd9, 32'd4, 3'b011, 5'd0, 1'b0);

    drive(mk_r(5'd1, 5'd2, 5'd0, 6'h27), 32'd8, 32'd6);
    drive(mk_r(5'd1, 5'd2, 5'd12, 6'h27), 32'd8, 32'd6);
    step(); chk_ex("nor", 32'd8, 32'd6, 3'b000, 5'd12, 1'b1);

    fwd1_we = 1'b1; fwd1_rd = 5'd1; fwd1_data = 32'hAA;
    fwd2_we = 1'b1; fwd2_rd = 5'd1; fwd2_data = 32'hBB;
    drive(mk_r(5'd1, 5'd2, 5'd7, 6'h24), 32'd5, 32'd7);
    step(); chk_ex("fwd1_wins", 32'hAA, 32'd7, 3'b001, 5'd7, 1'b1);

    fwd1_we = 1'b0;
    drive(mk_r(5'd2, 5'd1, 5'd7, 6'h25), 32'd5, 32'd7);
    step(); chk_ex("fwd2_b", 32'd5, 32'hBB, 3'b010, 5'd7, 1'b1);

    fwd1_we = 1'b1; fwd1_rd = 5'd0; fwd2_we = 1'b0;
    drive(mk_r(5'd0, 5'd1, 5'd8, 6'h25), 32'd123, 32'd7);
    step(); chk_ex("fwd_r0", 32'd0, 32'd7, 3'b010, 5'd8, 1'b1);
    fwd1_we = 1'b0; fwd1_rd = '0;

    drive(mk_r(5'd1, 5'd2, 5'd9, 6'h20), 32'd11, 32'd22);
    step(); chk_ex("pre_stall", 32'd11, 32'd22, 3'b100, 5'd9, 1'b1);
    out_ready = 1'b0;
    drive(mk_r(5'd3, 5'd4, 5'd10, 6'h22), 32'd33, 32'd44);
    #1;
    chk("stall.in_ready", 64'(in_ready), 64'(0));
    for (int i = 0; i < 3; i++) begin
      step();
      chk_ex("stall", 32'd11, 32'd22, 3'b100, 5'd9, 1'b1);
      chk("stall.in_ready", 64'(in_ready), 64'(0));
    end
    out_ready = 1'b1;
    #1;
    chk("unstall.in_ready", 64'(in_ready), 64'(1));
    step(); chk_ex("post_stall", 32'd33, 32'd44, 3'b011, 5'd10, 1'b1);

    flush = 1'b1;
    drive(mk_r(5'd1, 5'd2, 5'd11, 6'h20), 32'd55, 32'd66);
    #1;
    chk("flush.in_ready", 64'(in_ready), 64'(0));
    step();
    chk("flush.valid", 64'(out_valid), 64'(0));
    chk("flush.a",     64'(ex_a),      64'(33));
    chk("flush.rd",    64'(ex_rd),     64'(10));
    flush = 1'b0; in_valid = 1'b0;
    step();
    chk("idle.valid", 64'(out_valid), 64'(0));

    drive(mk_i(6'h3F, 5'd1, 5'd2, 16'h1234), 32'd5, 32'd7);
    step();
    chk("ill.illegal", 64'(ex_illegal),  64'(1));
    chk("ill.we",      64'(ex_we),       64'(0));
    chk("ill.op",      64'(ex_op),       64'(3'b111));
    chk("ill.a",       64'(ex_a),        64'(0));
    chk("ill.b",       64'(ex_b),        64'(0));
    chk("ill.cnt",     64'(illegal_cnt), 64'(1));
    chk("ill.scnt",    64'(s_cnt),       64'(1));
    for (int i = 0; i < 3; i++) begin
      drive(mk_r(5'd1, 5'd2, 5'd3, 6'h21), 32'd5, 32'd7);
      step();
    end
    chk("ill4.cnt",  64'(illegal_cnt), 64'(4));
    chk("sat.scnt",  64'(s_cnt),       64'(3));
    drive(mk_i(6'h08, 5'd0, 5'd1, 16'h0001), 32'd0, 32'd0);
    step();
    chk_ex("legal_after", 32'd0, 32'd1, 3'b100, 5'd1, 1'b1);
    chk("legal_after.cnt",  64'(illegal_cnt), 64'(4));
    chk("legal_after.scnt", 64'(s_cnt),       64'(3));

    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst.valid", 64'(out_valid),   64'(0));
    chk("midrst.op",    64'(ex_op),       64'(3'b111));
    chk("midrst.cnt",   64'(illegal_cnt), 64'(0));
    chk("midrst.scnt",  64'(s_cnt),       64'(0));
    in_valid = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    chk("midrst.in_ready", 64'(in_ready), 64'(1));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
